// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: fetches one instruction per PC value over a ready handshake,
// hands it to decode with valid/ready, and resolves BEQ/JMP into a branch + PC advance strobe.
module instr_fetch_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter logic [3:0]  OPC_BEQ = 4'hB,
  parameter logic [3:0]  OPC_JMP = 4'hC
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [ADDR_W-1:0]  address,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               zero,
  output logic               branch,
  output logic [ADDR_W-1:0]  sign_extended,
  output logic               pc_en
);

  typedef enum logic [2:0] {
    StRst,
    StReq,
    StWait,
    StHold,
    StAdv
  } state_e;

  state_e               state_q, state_d;
  logic                 imem_rd_q, imem_rd_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 branch_q, branch_d;
  logic [ADDR_W-1:0]    sext_q, sext_d;
  logic                 pc_en_q, pc_en_d;

  logic [3:0]           opcode;
  logic [ADDR_W-1:0]    offset_sext;
  logic                 take_branch;
  logic                 accept;

  assign opcode      = instr_q[INSTR_W-1 -: 4];
  assign offset_sext = ADDR_W'($signed(instr_q[7:0]));
  assign take_branch = (opcode == OPC_JMP) || ((opcode == OPC_BEQ) && zero);
  assign accept      = instr_valid_q && instr_ready;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    sext_d   = sext_q;
    branch_d = 1'b0;

    unique case (state_q)
      StRst:  state_d = StReq;
      StReq:  state_d = StWait;
      StWait: begin
        if (imem_ready) begin
          instr_d = imem_data;
          state_d = StHold;
        end
      end
      StHold: begin
        // zero is only meaningful at the acceptance edge of a BEQ
        if (accept) begin
          sext_d   = offset_sext;
          branch_d = take_branch;
          state_d  = StAdv;
        end
      end
      StAdv:   state_d = StReq;
      default: state_d = StRst;
    endcase

    // Output registers follow the state being entered so they line up with it.
    imem_rd_d     = (state_d == StReq) || (state_d == StWait);
    instr_valid_d = (state_d == StHold);
    pc_en_d       = (state_d == StAdv);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= StRst;
      imem_rd_q     <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      branch_q      <= 1'b0;
      sext_q        <= '0;
      pc_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_rd_q     <= imem_rd_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      branch_q      <= branch_d;
      sext_q        <= sext_d;
      pc_en_q       <= pc_en_d;
    end
  end

  assign imem_addr     = address;
  assign imem_rd       = imem_rd_q;
  assign instr         = instr_q;
  assign instr_valid   = instr_valid_q;
  assign branch        = branch_q;
  assign sign_extended = sext_q;
  assign pc_en         = pc_en_q;

  // Structural invariants of the handshake outputs.
  a_pc_en_in_adv: assert property (@(posedge CLK) disable iff (RESET)
    pc_en |-> (state_q == StAdv));
  a_valid_in_hold: assert property (@(posedge CLK) disable iff (RESET)
    instr_valid |-> (state_q == StHold));
  a_branch_with_pc_en: assert property (@(posedge CLK) disable iff (RESET)
    branch |-> pc_en);
  a_pc_en_single: assert property (@(posedge CLK) disable iff (RESET)
    pc_en |=> !pc_en);
  a_rd_matches_state: assert property (@(posedge CLK) disable iff (RESET)
    imem_rd == ((state_q == StReq) || (state_q == StWait)));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: table of fetch transactions plus a reset corner case,
// with a pc_en-driven scoreboard for branch/sign_extended.
module tb_instr_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  address = 8'hFE;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_ready = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        zero = 1'b0;
  logic        branch;
  logic [7:0]  sign_extended;
  logic        pc_en;

  instr_fetch_ctrl #(
    .ADDR_W (8),
    .INSTR_W(16),
    .OPC_BEQ(4'hB),
    .OPC_JMP(4'hC)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .address      (address),
    .imem_addr    (imem_addr),
    .imem_rd      (imem_rd),
    .imem_data    (imem_data),
    .imem_ready   (imem_ready),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .zero         (zero),
    .branch       (branch),
    .sign_extended(sign_extended),
    .pc_en        (pc_en)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic        zero;
    int          waits;
    int          bp;
    logic        exp_branch;
    logic [7:0]  exp_sext;
    int          exp_rd;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic        branch;
    logic [7:0]  sext;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] prev_instr = 16'h0000;
  logic        prev_pc_en = 1'b0;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard consumer: each pc_en pulse retires one expected branch decision.
  always @(negedge CLK) begin
    exp_t e;
    if (pc_en) begin
      check("sb_pending", {31'b0, sb_q.size() != 0}, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_branch", {31'b0, branch}, {31'b0, e.branch});
        check("sb_sext", {24'b0, sign_extended}, {24'b0, e.sext});
        check("sb_instr", {16'b0, instr}, {16'b0, e.instr});
      end
      check("pc_en_width", {31'b0, prev_pc_en}, 0);
      check("valid_in_adv", {31'b0, instr_valid}, 0);
    end
    prev_pc_en = pc_en;
  end

  // One complete fetch/decode/advance transaction; starts at the edge+1 point of any cycle.
  task automatic fetch(input vec_t v);
    exp_t e;
    int   cnt;
    int   rd_cnt;
    cnt = 0;
    while (!imem_rd && cnt < 20) begin
      tick;
      cnt++;
    end
    check("rd_start", {31'b0, imem_rd}, 1);
    check("imem_addr", {24'b0, imem_addr}, {24'b0, address});
    // S_REQ cycle
    rd_cnt     = 1;
    imem_ready = (v.waits == 0);
    imem_data  = (v.waits == 0) ? v.data : 16'hDEAD;
    instr_ready = 1'b0;
    tick;
    for (int w = 0; w <= v.waits; w++) begin
      if (imem_rd) rd_cnt++;
      check("wait_rd", {31'b0, imem_rd}, 1);
      check("wait_valid", {31'b0, instr_valid}, 0);
      check("wait_instr", {16'b0, instr}, {16'b0, prev_instr});
      if (w == v.waits) begin
        imem_ready  = 1'b1;
        imem_data   = v.data;
        instr_ready = (v.bp == 0);
        e.instr  = v.data;
        e.branch = v.exp_branch;
        e.sext   = v.exp_sext;
        sb_q.push_back(e);
      end else begin
        imem_ready = 1'b0;
        imem_data  = 16'hDEAD;
      end
      tick;
    end
    check("rd_cycles", rd_cnt, v.exp_rd);
    // S_HOLD: memory handshake lines now ignored
    imem_ready = 1'b1;
    imem_data  = 16'hBAD0;
    for (int b = 0; b <= v.bp; b++) begin
      check("hold_valid", {31'b0, instr_valid}, 1);
      check("hold_instr", {16'b0, instr}, {16'b0, v.data});
      check("hold_pc_en", {31'b0, pc_en}, 0);
      check("hold_rd", {31'b0, imem_rd}, 0);
      if (b == v.bp) begin
        instr_ready = 1'b1;
        zero        = v.zero;
      end else begin
        instr_ready = 1'b0;
        zero        = ~v.zero;
      end
      tick;
    end
    // S_ADV
    check("adv_pc_en", {31'b0, pc_en}, 1);
    check("adv_branch", {31'b0, branch}, {31'b0, v.exp_branch});
    check("adv_sext", {24'b0, sign_extended}, {24'b0, v.exp_sext});
    instr_ready = 1'b0;
    imem_ready  = 1'b0;
    zero        = ~zero;
    tick;
    check("post_pc_en", {31'b0, pc_en}, 0);
    check("post_branch", {31'b0, branch}, 0);
    address = v.exp_branch ? address + v.exp_sext : address + 8'd1;
    prev_instr = v.data;
    #1;
    check("imem_addr_follow", {24'b0, imem_addr}, {24'b0, address});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 0, 0, 1'b0, 8'h34, 2};
    vecs[1] = '{16'hB0FC, 1'b1, 0, 0, 1'b1, 8'hFC, 2};
    vecs[2] = '{16'hB0FC, 1'b0, 0, 0, 1'b0, 8'hFC, 2};
    vecs[3] = '{16'hC005, 1'b0, 0, 0, 1'b1, 8'h05, 2};
    vecs[4] = '{16'hC005, 1'b1, 2, 0, 1'b1, 8'h05, 4};
    vecs[5] = '{16'hA080, 1'b1, 1, 5, 1'b0, 8'h80, 3};
    vecs[6] = '{16'hB07F, 1'b1, 0, 2, 1'b1, 8'h7F, 2};
    vecs[7] = '{16'hCFFF, 1'b0, 3, 1, 1'b1, 8'hFF, 5};

    tick;
    tick;
    check("rst_rd", {31'b0, imem_rd}, 0);
    check("rst_instr", {16'b0, instr}, 0);
    check("rst_valid", {31'b0, instr_valid}, 0);
    check("rst_branch", {31'b0, branch}, 0);
    check("rst_sext", {24'b0, sign_extended}, 0);
    check("rst_pc_en", {31'b0, pc_en}, 0);
    RESET = 1'b0;
    check("rel_rd", {31'b0, imem_rd}, 0);

    for (int i = 0; i < 8; i++) fetch(vecs[i]);

    // Asynchronous reset with a request outstanding, then a late imem_ready.
    imem_ready  = 1'b0;
    instr_ready = 1'b0;
    tick;
    check("abort_wait_rd", {31'b0, imem_rd}, 1);
    tick;
    #2;
    RESET = 1'b1;
    #1;
    check("arst_rd", {31'b0, imem_rd}, 0);
    check("arst_instr", {16'b0, instr}, 0);
    check("arst_valid", {31'b0, instr_valid}, 0);
    check("arst_sext", {24'b0, sign_extended}, 0);
    check("arst_pc_en", {31'b0, pc_en}, 0);
    imem_ready = 1'b1;
    imem_data  = 16'hBEEF;
    tick;
    tick;
    RESET = 1'b0;
    check("late_rdy_rd", {31'b0, imem_rd}, 0);
    tick;
    check("restart_rd", {31'b0, imem_rd}, 1);
    check("restart_instr", {16'b0, instr}, 0);
    check("restart_valid", {31'b0, instr_valid}, 0);
    prev_instr = 16'h0000;
    fetch(vecs[0]);

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
